// File: rtl/gate_array.sv
// Registered bitwise gate unit with a one-entry valid/ready output register
// and a built-in sweep engine that self-checks all eight gates on all 2-input rows.
module gate_array #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] o,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [5:0]       sig,
    output logic             sweep_fail
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [4:0]       step;
    logic [2:0]       gate_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             start;
    logic             accept;
    logic             consume;

    // A sweep request in IDLE wins over a same-cycle operation.
    always_comb begin
        start    = (state == IDLE) && sweep_start;
        in_ready = (state == IDLE) && !sweep_start && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        consume  = out_valid && out_ready;
    end

    assign sweep_busy = (state == SWEEP);
    assign sweep_done = (state == DONE);

    // The sweep shares the gate datapath so it exercises the real logic.
    always_comb begin
        gate_op = op;
        a       = i1;
        b       = i2;
        if (state == SWEEP) begin
            gate_op = step[4:2];
            a       = {WIDTH{step[1]}};
            b       = {WIDTH{step[0]}};
        end
    end

    always_comb begin
        r = '0;
        case (gate_op)
            3'd0: r = a;
            3'd1: r = ~a;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ~(a | b);
            3'd5: r = ~(a & b);
            3'd6: r = a ^ b;
            3'd7: r = ~(a ^ b);
            default: r = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SWEEP;
            SWEEP:   if (step == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o         <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            o         <= r;
            out_valid <= 1'b1;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    // A correct gate always yields a result with every bit equal to bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step       <= '0;
            sig        <= '0;
            sweep_fail <= 1'b0;
        end else if (start) begin
            step       <= '0;
            sig        <= '0;
            sweep_fail <= 1'b0;
        end else if (state == SWEEP) begin
            step       <= step + 5'd1;
            sig        <= sig + {5'b0, r[0]};
            sweep_fail <= sweep_fail | (r != {WIDTH{r[0]}});
        end
    end

endmodule
